mem_port_arbiter: RTL and testbench

- Sequences the core's single shared memory port between instruction fetch (IF) and load/store (LS) requesters.
- Generates byte enables and lane-aligned write data from the controller's store-size encoding.
- Extracts and sign/zero-extends load data from the controller's load-type encoding.
- Detects misaligned accesses and memory timeouts, and drives the core stall while a transaction is pending.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter_ls_lane_align.sv | 32 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings, state type and alignment helper for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_WAIT, LS_WAIT, RESP} state_t;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP = {25'b0, OPC_OP_IMM};
  localparam logic [2:0] LD_LW = 3'd1;
  localparam logic [2:0] LD_LB = 3'd2;
  localparam logic [2:0] LD_LH = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;
  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;
  // loads take their access width from the load type, stores from the size field
  function automatic logic misaligned(input logic we, input logic [1:0] size, input logic [2:0] ld_type,
                                      input logic [1:0] off);
    logic [1:0] sz;
    sz = we ? size :
         (ld_type == LD_LB || ld_type == LD_LBU) ? SZ_BYTE :
         (ld_type == LD_LH || ld_type == LD_LHU) ? SZ_HALF : SZ_WORD;
    return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00) || (we && size == SZ_NONE);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [2:0]        ls_ld_type;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic              ls_err;
  logic [31:0]       ls_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              stall;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_ld_type, ls_addr, ls_wdata, mem_ready, mem_rdata,
    output if_rvalid, if_rdata, ls_done, ls_err, ls_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_ld_type, ls_addr, ls_wdata, mem_ready, mem_rdata,
    input  if_rvalid, if_rdata, ls_done, ls_err, ls_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter_ls_lane_align.sv
// ls_lane_align: store byte enables / lane replication and load lane extraction with extension
module ls_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    be = size == SZ_BYTE ? 4'b0001 << st_off :
         size == SZ_HALF ? 4'b0011 << {st_off[1], 1'b0} : 4'b1111;
    wdata = size == SZ_BYTE ? {4{st_data[7:0]}} :
            size == SZ_HALF ? {2{st_data[15:0]}} : st_data;
    sh = ld_data >> {ld_off, 3'b000};
    b = sh[7:0];
    h = sh[15:0];
    rdata = ld_type == LD_LW  ? ld_data :
            ld_type == LD_LB  ? {{24{b[7]}}, b} :
            ld_type == LD_LH  ? {{16{h[15]}}, h} :
            ld_type == LD_LBU ? {24'b0, b} :
            ld_type == LD_LHU ? {16'b0, h} : ld_data;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the shared memory port between fetch and load/store with
// starvation control, alignment checks, timeout abort and core stall
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 15,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t            state;
  logic [TW-1:0]     tcnt;
  logic [SW-1:0]     starve_cnt;
  logic              ld_we;
  logic [2:0]        ld_type;
  logic [1:0]        ld_off;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_ext;
  logic              grant_ls;
  logic              grant_if;
  logic              mis;
  always_comb begin
    grant_ls = bus.ls_req && (starve_cnt < SW'(STARVE_MAX) || !bus.if_req);
    grant_if = bus.if_req && !grant_ls;
    mis = misaligned(bus.ls_we, bus.ls_size, bus.ls_ld_type, bus.ls_addr[1:0]);
  end
  assign bus.stall = (bus.ls_req & ~bus.ls_done) | (bus.if_req & ~bus.if_rvalid);
  ls_lane_align u_align (
    .size    (bus.ls_size),
    .st_off  (bus.ls_addr[1:0]),
    .st_data (bus.ls_wdata),
    .ld_type (ld_type),
    .ld_off  (ld_off),
    .ld_data (bus.mem_rdata),
    .be      (st_be),
    .wdata   (st_wdata),
    .rdata   (ld_ext)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tcnt <= '0;
      starve_cnt <= '0;
      ld_we <= 1'b0;
      ld_type <= '0;
      ld_off <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata <= '0;
      bus.ls_done <= 1'b0;
      bus.ls_err <= 1'b0;
      bus.ls_rdata <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_be <= '0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ls) begin
            starve_cnt <= bus.if_req ? starve_cnt + SW'(1) : starve_cnt;
            ld_we <= bus.ls_we;
            ld_type <= bus.ls_ld_type;
            ld_off <= bus.ls_addr[1:0];
            if (mis) begin
              state <= RESP;
              bus.ls_done <= 1'b1;
              bus.ls_err <= 1'b1;
            end else begin
              state <= LS_WAIT;
              bus.mem_req <= 1'b1;
              bus.mem_we <= bus.ls_we;
              bus.mem_be <= bus.ls_we ? st_be : 4'b1111;
              bus.mem_addr <= bus.ls_addr & ~ADDR_W'(3);
              bus.mem_wdata <= bus.ls_we ? st_wdata : '0;
            end
          end else if (grant_if) begin
            starve_cnt <= '0;
            state <= IF_WAIT;
            bus.mem_req <= 1'b1;
            bus.mem_we <= 1'b0;
            bus.mem_be <= 4'b1111;
            bus.mem_addr <= bus.if_addr & ~ADDR_W'(3);
            bus.mem_wdata <= '0;
          end
        end
        IF_WAIT, LS_WAIT: begin
          if (bus.mem_ready || tcnt == TW'(TIMEOUT - 1)) begin
            state <= RESP;
            tcnt <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_we <= 1'b0;
            if (state == LS_WAIT) begin
              bus.ls_done <= 1'b1;
              bus.ls_err <= !bus.mem_ready;
              bus.ls_rdata <= (bus.mem_ready && !ld_we) ? ld_ext : '0;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : NOP;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          bus.if_rvalid <= 1'b0;
          bus.if_rdata <= '0;
          bus.ls_done <= 1'b0;
          bus.ls_err <= 1'b0;
          bus.ls_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table of single load/store transactions plus directed
// sequences for starvation, timeouts and mid-transaction reset
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [2:0]  lt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    logic        mis;
    logic [31:0] exp_rd;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vecs[15];
  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ls(input vec_t v, input int idx);
    bus.ls_req = 1'b1;
    bus.ls_we = v.we;
    bus.ls_size = v.size;
    bus.ls_ld_type = v.lt;
    bus.ls_addr = v.addr;
    bus.ls_wdata = v.wdata;
    #1 chk($sformatf("v%0d_stall_req", idx), bus.stall, 1);
    step();
    if (v.mis) begin
      chk($sformatf("v%0d_mis_mem_req", idx), bus.mem_req, 0);
      chk($sformatf("v%0d_mis_done_err", idx), {bus.ls_done, bus.ls_err}, 2'b11);
    end else begin
      chk($sformatf("v%0d_mem_req", idx), bus.mem_req, 1);
      chk($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.maddr);
      chk($sformatf("v%0d_mem_we", idx), bus.mem_we, v.we);
      chk($sformatf("v%0d_mem_be", idx), bus.mem_be, v.be);
      if (v.we) chk($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.mwdata);
      chk($sformatf("v%0d_early_done", idx), bus.ls_done, 0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = v.rdata;
      step();
      bus.mem_ready = 1'b0;
      chk($sformatf("v%0d_done_err", idx), {bus.ls_done, bus.ls_err}, 2'b10);
      chk($sformatf("v%0d_rdata", idx), bus.ls_rdata, v.exp_rd);
      chk($sformatf("v%0d_mem_req_drop", idx), bus.mem_req, 0);
    end
    chk($sformatf("v%0d_stall_done", idx), bus.stall, 0);
    bus.ls_req = 1'b0;
    step();
    chk($sformatf("v%0d_done_pulse", idx), bus.ls_done, 0);
  endtask

  initial begin
    int n;
    int cnt;
    logic seen;
    bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0;
    bus.ls_ld_type = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    //          we  size     lt      addr        wdata         rdata         be       mwdata        maddr       mis  exp_rd
    vecs[0]  = '{0, SZ_NONE, LD_LB,  32'h103, 32'h0,        32'h8000_0000, 4'b1111, 32'h0,        32'h100, 0, 32'hFFFF_FF80};
    vecs[1]  = '{0, SZ_NONE, LD_LBU, 32'h103, 32'h0,        32'h8000_0000, 4'b1111, 32'h0,        32'h100, 0, 32'h0000_0080};
    vecs[2]  = '{1, SZ_HALF, 3'd0,   32'h102, 32'h0000_BEEF, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h100, 0, 32'h0};
    vecs[3]  = '{1, SZ_WORD, 3'd0,   32'h101, 32'h1111_2222, 32'h0,        4'b1111, 32'h0,        32'h100, 1, 32'h0};
    vecs[4]  = '{1, SZ_BYTE, 3'd0,   32'h201, 32'h1234_56AB, 32'h0,        4'b0010, 32'hABAB_ABAB, 32'h200, 0, 32'h0};
    vecs[5]  = '{1, SZ_WORD, 3'd0,   32'h204, 32'hDEAD_BEEF, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h204, 0, 32'h0};
    vecs[6]  = '{0, SZ_NONE, LD_LH,  32'h302, 32'h0,        32'h8001_7FFF, 4'b1111, 32'h0,        32'h300, 0, 32'hFFFF_8001};
    vecs[7]  = '{0, SZ_NONE, LD_LHU, 32'h302, 32'h0,        32'h8001_7FFF, 4'b1111, 32'h0,        32'h300, 0, 32'h0000_8001};
    vecs[8]  = '{0, SZ_NONE, LD_LH,  32'h300, 32'h0,        32'h8001_7FFF, 4'b1111, 32'h0,        32'h300, 0, 32'h0000_7FFF};
    vecs[9]  = '{0, SZ_NONE, LD_LW,  32'h304, 32'h0,        32'hCAFE_F00D, 4'b1111, 32'h0,        32'h304, 0, 32'hCAFE_F00D};
    vecs[10] = '{0, SZ_NONE, LD_LB,  32'h401, 32'h0,        32'h1234_F278, 4'b1111, 32'h0,        32'h400, 0, 32'hFFFF_FFF2};
    vecs[11] = '{1, SZ_HALF, 3'd0,   32'h101, 32'h0000_1234, 32'h0,        4'b1111, 32'h0,        32'h100, 1, 32'h0};
    vecs[12] = '{1, SZ_NONE, 3'd0,   32'h100, 32'h0000_1234, 32'h0,        4'b1111, 32'h0,        32'h100, 1, 32'h0};
    vecs[13] = '{0, SZ_NONE, 3'd7,   32'h108, 32'h0,        32'h8765_4321, 4'b1111, 32'h0,        32'h108, 0, 32'h8765_4321};
    vecs[14] = '{1, SZ_BYTE, 3'd0,   32'h103, 32'h0000_00C5, 32'h0,        4'b1000, 32'hC5C5_C5C5, 32'h100, 0, 32'h0};
    step();
    step();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_done", {bus.ls_done, bus.ls_err, bus.if_rvalid}, 0);
    chk("rst_stall", bus.stall, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 15; i++) run_ls(vecs[i], i);

    // both requesters held: four LS completions, then the forced IF, repeating
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = SZ_NONE; bus.ls_ld_type = LD_LW; bus.ls_addr = 32'h2000;
    bus.if_req = 1; bus.if_addr = 32'h1000; bus.mem_rdata = 32'h0011_2233;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      step();
      bus.mem_ready = bus.mem_req;
      if (bus.ls_done || bus.if_rvalid) begin
        chk($sformatf("order_%0d_is_if", n), bus.if_rvalid, (n == 4 || n == 9) ? 1 : 0);
        chk($sformatf("order_%0d_rdata", n), bus.if_rvalid ? bus.if_rdata : bus.ls_rdata, 32'h0011_2233);
        n++;
      end
    end
    chk("order_count", n, 10);
    bus.ls_req = 0; bus.if_req = 0; bus.mem_ready = 0;
    step();
    step();

    // LS timeout: mem_ready never arrives
    bus.ls_req = 1; bus.ls_addr = 32'h40; bus.ls_ld_type = LD_LW;
    cnt = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (bus.mem_req) cnt++;
      if (bus.ls_done) begin
        seen = 1;
        chk("ls_to_req_cycles", cnt, 15);
        chk("ls_to_err", bus.ls_err, 1);
        chk("ls_to_stall", bus.stall, 0);
      end
    end
    chk("ls_to_seen", seen, 1);
    bus.ls_req = 0;
    step();

    // fetch timeout returns a NOP
    bus.if_req = 1; bus.if_addr = 32'h80;
    cnt = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (bus.mem_req) cnt++;
      if (bus.if_rvalid) begin
        seen = 1;
        chk("if_to_req_cycles", cnt, 15);
        chk("if_to_nop", bus.if_rdata, 32'h0000_0013);
      end
    end
    chk("if_to_seen", seen, 1);
    bus.if_req = 0;
    step();

    // reset while an LS access is waiting on memory
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_ld_type = LD_LW; bus.ls_addr = 32'h500;
    step();
    chk("mid_rst_pre_req", bus.mem_req, 1);
    rst_n = 0;
    step();
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_stall", bus.stall, 1);
    rst_n = 1;
    bus.ls_req = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mid_rst_no_done_%0d", c), {bus.ls_done, bus.mem_req}, 0);
    end
    run_ls(vecs[9], 99);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
